// File: rtl/usb_protocol_ctrl.sv
// Bulk-endpoint transaction sequencer: tracks OUT/IN transactions from receiver status and picks the transmitter packet.
// Optional USB_CTRL_TIMEOUT_EN bounds the wait for the host ACK after an IN data packet.
module usb_protocol_ctrl #(
    parameter int BUF_DEPTH      = 64,
    parameter int MAX_PKT        = 64,
    parameter int TIMEOUT_CYCLES = 640
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] rx_packet,
    input  logic       store_rx_packet_data,
    input  logic [6:0] buffer_occupancy,
    input  logic       tx_data_ready,
    input  logic       tx_done,
    output logic [2:0] tx_packet,
    output logic       d_mode,
    output logic       clear_buffer,
    output logic       rx_data_ready,
    output logic       tx_transfer_done,
    output logic       rx_error,
    output logic       tx_error,
    output logic       busy
);
    localparam logic [2:0] RX_IN = 3'd1, RX_OUT = 3'd2, RX_ACK = 3'd3, RX_NAK = 3'd4;
    localparam logic [2:0] RX_DONE = 3'd5, RX_DATA = 3'd6, RX_ERROR = 3'd7;
    localparam logic [2:0] TX_NONE = 3'd0, TX_DATA0 = 3'd1, TX_ACK = 3'd2, TX_NAK = 3'd3;

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [3:0] {
        IDLE, OUT_TOKEN, OUT_WAIT, OUT_DATA, OUT_HS,
        IN_TOKEN, IN_DATA, IN_NAK, IN_WAIT_ACK
    } state_t;

    state_t     state_reg, state_next;
    logic [2:0] rx_prev_reg;
    logic       room_reg, room_next;
    logic [7:0] cnt_reg, cnt_next, cnt_plus;
    logic       hs_nak_reg, hs_nak_next;
    logic [2:0] tx_packet_reg, tx_packet_next;
    logic       d_mode_reg, d_mode_next;
    logic       clear_buffer_reg, clear_buffer_next;
    logic       rx_data_ready_reg, rx_data_ready_next;
    logic       tx_transfer_done_reg, tx_transfer_done_next;
    logic       rx_error_reg, rx_error_next;
    logic       tx_error_reg, tx_error_next;
    logic       ev, room_calc, wait_exit;

`ifdef USB_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_reg, tmo_next;
`endif

    assign ev        = (rx_packet != rx_prev_reg);
    assign room_calc = (BUF_DEPTH - int'(buffer_occupancy)) >= MAX_PKT;
    // A byte strobed on the DONE cycle still counts toward the length check.
    assign cnt_plus  = (store_rx_packet_data && cnt_reg != 8'hFF) ? cnt_reg + 8'd1 : cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg            <= IDLE;
            rx_prev_reg          <= 3'd0;
            room_reg             <= 1'b0;
            cnt_reg              <= 8'd0;
            hs_nak_reg           <= 1'b0;
            tx_packet_reg        <= TX_NONE;
            d_mode_reg           <= 1'b0;
            clear_buffer_reg     <= 1'b0;
            rx_data_ready_reg    <= 1'b0;
            tx_transfer_done_reg <= 1'b0;
            rx_error_reg         <= 1'b0;
            tx_error_reg         <= 1'b0;
`ifdef USB_CTRL_TIMEOUT_EN
            tmo_reg              <= '0;
`endif
        end else begin
            state_reg            <= state_next;
            rx_prev_reg          <= rx_packet;
            room_reg             <= room_next;
            cnt_reg              <= cnt_next;
            hs_nak_reg           <= hs_nak_next;
            tx_packet_reg        <= tx_packet_next;
            d_mode_reg           <= d_mode_next;
            clear_buffer_reg     <= clear_buffer_next;
            rx_data_ready_reg    <= rx_data_ready_next;
            tx_transfer_done_reg <= tx_transfer_done_next;
            rx_error_reg         <= rx_error_next;
            tx_error_reg         <= tx_error_next;
`ifdef USB_CTRL_TIMEOUT_EN
            tmo_reg              <= tmo_next;
`endif
        end
    end

    always_comb begin
        state_next            = state_reg;
        room_next             = room_reg;
        cnt_next              = cnt_reg;
        hs_nak_next           = hs_nak_reg;
        clear_buffer_next     = 1'b0;
        rx_data_ready_next    = 1'b0;
        tx_transfer_done_next = 1'b0;
        rx_error_next         = 1'b0;
        tx_error_next         = 1'b0;
        wait_exit             = 1'b0;
`ifdef USB_CTRL_TIMEOUT_EN
        tmo_next              = '0;
`endif
        if (ev && rx_packet == RX_ERROR) begin
            state_next        = IDLE;
            rx_error_next     = 1'b1;
            clear_buffer_next = (state_reg == OUT_DATA);
        end else begin
            case (state_reg)
                IDLE: begin
                    if (ev && rx_packet == RX_OUT) begin
                        state_next = OUT_TOKEN;
                        room_next  = room_calc;
                    end else if (ev && rx_packet == RX_IN) begin
                        state_next = IN_TOKEN;
                    end
                end
                OUT_TOKEN: begin
                    if (ev) begin
                        if (rx_packet == RX_DONE) begin
                            state_next = OUT_WAIT;
                        end else begin
                            state_next    = IDLE;
                            rx_error_next = 1'b1;
                        end
                    end
                end
                OUT_WAIT: begin
                    if (ev && rx_packet == RX_DATA) begin
                        state_next = OUT_DATA;
                        cnt_next   = 8'd0;
                    end
                end
                OUT_DATA: begin
                    cnt_next = cnt_plus;
                    if (ev && rx_packet == RX_DONE) begin
                        if (int'(cnt_plus) > MAX_PKT) begin
                            state_next        = IDLE;
                            rx_error_next     = 1'b1;
                            clear_buffer_next = 1'b1;
                        end else if (!room_reg) begin
                            state_next        = OUT_HS;
                            hs_nak_next       = 1'b1;
                            clear_buffer_next = 1'b1;
                        end else begin
                            state_next         = OUT_HS;
                            hs_nak_next        = 1'b0;
                            rx_data_ready_next = 1'b1;
                        end
                    end
                end
                OUT_HS:  if (tx_done) state_next = IDLE;
                IN_TOKEN: begin
                    if (ev && rx_packet == RX_DONE)
                        state_next = tx_data_ready ? IN_DATA : IN_NAK;
                end
                IN_DATA: if (tx_done) state_next = IN_WAIT_ACK;
                IN_NAK:  if (tx_done) state_next = IDLE;
                IN_WAIT_ACK: begin
                    if (ev && rx_packet == RX_ACK) begin
                        wait_exit             = 1'b1;
                        tx_transfer_done_next = 1'b1;
                        clear_buffer_next     = 1'b1;
                    end else if (ev && (rx_packet == RX_NAK || rx_packet == RX_IN ||
                                        rx_packet == RX_OUT)) begin
                        wait_exit     = 1'b1;
                        tx_error_next = 1'b1;
                    end
`ifdef USB_CTRL_TIMEOUT_EN
                    else if (tmo_reg == TW'(TIMEOUT_CYCLES - 1)) begin
                        wait_exit     = 1'b1;
                        tx_error_next = 1'b1;
                    end
                    tmo_next = tmo_reg + 1'b1;
`endif
                    if (wait_exit) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        tx_packet_next = TX_NONE;
        d_mode_next    = 1'b0;
        case (state_next)
            OUT_HS: begin
                tx_packet_next = hs_nak_next ? TX_NAK : TX_ACK;
                d_mode_next    = 1'b1;
            end
            IN_DATA: begin
                tx_packet_next = TX_DATA0;
                d_mode_next    = 1'b1;
            end
            IN_NAK: begin
                tx_packet_next = TX_NAK;
                d_mode_next    = 1'b1;
            end
            default: ;
        endcase
    end

    assign tx_packet        = tx_packet_reg;
    assign d_mode           = d_mode_reg;
    assign clear_buffer     = clear_buffer_reg;
    assign rx_data_ready    = rx_data_ready_reg;
    assign tx_transfer_done = tx_transfer_done_reg;
    assign rx_error         = rx_error_reg;
    assign tx_error         = tx_error_reg;
    assign busy             = (state_reg != IDLE);
endmodule

// File: tb/tb_usb_protocol_ctrl.sv
// Directed bench for usb_protocol_ctrl: per-cycle vector table plus hand-written multi-cycle sequences.
module tb_usb_protocol_ctrl;
    logic       tb_clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] rx_packet = 3'd0;
    logic       store_rx_packet_data = 1'b0;
    logic [6:0] buffer_occupancy = 7'd0;
    logic       tx_data_ready = 1'b0;
    logic       tx_done = 1'b0;
    logic [2:0] tx_packet;
    logic       d_mode, clear_buffer, rx_data_ready, tx_transfer_done;
    logic       rx_error, tx_error, busy;
    logic [9:0] act;

    int checks = 0;
    int errors = 0;

    always #5 tb_clk = ~tb_clk;

    usb_protocol_ctrl dut (
        .clk(tb_clk), .rst(rst), .rx_packet(rx_packet),
        .store_rx_packet_data(store_rx_packet_data), .buffer_occupancy(buffer_occupancy),
        .tx_data_ready(tx_data_ready), .tx_done(tx_done), .tx_packet(tx_packet),
        .d_mode(d_mode), .clear_buffer(clear_buffer), .rx_data_ready(rx_data_ready),
        .tx_transfer_done(tx_transfer_done), .rx_error(rx_error), .tx_error(tx_error),
        .busy(busy)
    );

    // Output bundle: {tx_packet[2:0], d_mode, clear_buffer, rx_data_ready, tx_transfer_done, rx_error, tx_error, busy}
    assign act = {tx_packet, d_mode, clear_buffer, rx_data_ready, tx_transfer_done, rx_error, tx_error, busy};

    typedef struct {
        logic       rst;
        logic [2:0] rxp;
        logic       st;
        logic [6:0] occ;
        logic       tdr;
        logic       tdone;
        logic [9:0] exp;
    } vec_t;

    localparam int NV = 49;
    vec_t vecs[NV];

    logic [9:0] Z, B, ACKR, ACKH, D0, NAKH, NAKC, TTDC, RXE, RXEC, TXE;

    function automatic logic [9:0] mk(input logic [2:0] t, input logic dm, input logic clr,
                                      input logic rdr, input logic ttd, input logic rxe,
                                      input logic txe, input logic bsy);
        return {t, dm, clr, rdr, ttd, rxe, txe, bsy};
    endfunction

    task automatic tick();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [9:0] a, input logic [9:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got=%b want=%b", name, a, e);
        end else begin
            $display("ok   %s out=%b", name, a);
        end
    endtask

    task automatic check_int(input string name, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, a, e);
        end else begin
            $display("ok   %s value=%0d", name, a);
        end
    endtask

    task automatic step(input string name, input logic [2:0] rxp, input logic st,
                        input logic [9:0] e);
        rx_packet = rxp;
        store_rx_packet_data = st;
        tick();
        store_rx_packet_data = 1'b0;
        check(name, act, e);
    endtask

    task automatic done_step(input string name, input logic [9:0] e);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check(name, act, e);
    endtask

    task automatic out_prefix(input string name);
        buffer_occupancy = 7'd0;
        step({name, "_idle"}, 3'd0, 1'b0, Z);
        step({name, "_out"}, 3'd2, 1'b0, B);
        step({name, "_done"}, 3'd5, 1'b0, B);
        step({name, "_data"}, 3'd6, 1'b0, B);
    endtask

    initial begin
        int k;
        int txe_seen;
        bit got;

        Z    = '0;
        B    = mk(3'd0, 0, 0, 0, 0, 0, 0, 1);
        ACKR = mk(3'd2, 1, 0, 1, 0, 0, 0, 1);
        ACKH = mk(3'd2, 1, 0, 0, 0, 0, 0, 1);
        D0   = mk(3'd1, 1, 0, 0, 0, 0, 0, 1);
        NAKH = mk(3'd3, 1, 0, 0, 0, 0, 0, 1);
        NAKC = mk(3'd3, 1, 1, 0, 0, 0, 0, 1);
        TTDC = mk(3'd0, 0, 1, 0, 1, 0, 0, 0);
        RXE  = mk(3'd0, 0, 0, 0, 0, 1, 0, 0);
        RXEC = mk(3'd0, 0, 1, 0, 0, 1, 0, 0);
        TXE  = mk(3'd0, 0, 0, 0, 0, 0, 1, 0);

        //            rst rxp  st occ  tdr tdone exp
        vecs[0]  = '{1, 3'd0, 0, 7'd0, 0, 0, Z};
        vecs[1]  = '{0, 3'd0, 0, 7'd0, 0, 0, Z};
        vecs[2]  = '{0, 3'd2, 0, 7'd0, 0, 0, B};     // OUT token, room latched
        vecs[3]  = '{0, 3'd2, 0, 7'd0, 0, 0, B};
        vecs[4]  = '{0, 3'd5, 0, 7'd0, 0, 0, B};
        vecs[5]  = '{0, 3'd6, 0, 7'd0, 0, 0, B};
        vecs[6]  = '{0, 3'd6, 1, 7'd0, 0, 0, B};
        vecs[7]  = '{0, 3'd6, 1, 7'd0, 0, 0, B};
        vecs[8]  = '{0, 3'd5, 1, 7'd0, 0, 0, ACKR};  // 3 bytes, ACK
        vecs[9]  = '{0, 3'd5, 0, 7'd0, 0, 0, ACKH};
        vecs[10] = '{0, 3'd0, 0, 7'd0, 0, 0, ACKH};  // NONE event ignored
        vecs[11] = '{0, 3'd0, 0, 7'd0, 0, 1, Z};
        vecs[12] = '{0, 3'd0, 0, 7'd0, 0, 0, Z};
        vecs[13] = '{0, 3'd1, 0, 7'd0, 1, 0, B};     // IN with data ready
        vecs[14] = '{0, 3'd5, 0, 7'd0, 1, 0, D0};
        vecs[15] = '{0, 3'd5, 0, 7'd0, 1, 0, D0};
        vecs[16] = '{0, 3'd5, 0, 7'd0, 1, 1, B};
        vecs[17] = '{0, 3'd0, 0, 7'd0, 0, 0, B};
        vecs[18] = '{0, 3'd3, 0, 7'd0, 0, 0, TTDC};
        vecs[19] = '{0, 3'd3, 0, 7'd0, 0, 0, Z};
        vecs[20] = '{0, 3'd1, 0, 7'd0, 0, 0, B};     // IN without data
        vecs[21] = '{0, 3'd5, 0, 7'd0, 0, 0, NAKH};
        vecs[22] = '{0, 3'd5, 0, 7'd0, 0, 1, Z};
        vecs[23] = '{0, 3'd2, 0, 7'd10, 0, 0, B};    // OUT with no room
        vecs[24] = '{0, 3'd5, 0, 7'd0, 0, 0, B};
        vecs[25] = '{0, 3'd6, 0, 7'd0, 0, 0, B};
        vecs[26] = '{0, 3'd6, 1, 7'd0, 0, 0, B};
        vecs[27] = '{0, 3'd5, 0, 7'd0, 0, 0, NAKC};
        vecs[28] = '{0, 3'd5, 0, 7'd0, 0, 0, NAKH};
        vecs[29] = '{0, 3'd5, 0, 7'd0, 0, 1, Z};
        vecs[30] = '{0, 3'd2, 0, 7'd0, 0, 0, B};     // OUT token then IN: protocol error
        vecs[31] = '{0, 3'd1, 0, 7'd0, 0, 0, RXE};
        vecs[32] = '{0, 3'd1, 0, 7'd0, 0, 0, Z};
        vecs[33] = '{0, 3'd2, 0, 7'd0, 0, 0, B};     // ERROR during OUT_DATA
        vecs[34] = '{0, 3'd5, 0, 7'd0, 0, 0, B};
        vecs[35] = '{0, 3'd6, 0, 7'd0, 0, 0, B};
        vecs[36] = '{0, 3'd7, 0, 7'd0, 0, 0, RXEC};
        vecs[37] = '{0, 3'd7, 0, 7'd0, 0, 0, Z};
        vecs[38] = '{0, 3'd1, 0, 7'd0, 1, 0, B};     // IN, host NAKs the data
        vecs[39] = '{0, 3'd5, 0, 7'd0, 1, 0, D0};
        vecs[40] = '{0, 3'd5, 0, 7'd0, 1, 1, B};
        vecs[41] = '{0, 3'd4, 0, 7'd0, 0, 0, TXE};
        vecs[42] = '{0, 3'd4, 0, 7'd0, 0, 0, Z};
        vecs[43] = '{0, 3'd4, 0, 7'd0, 0, 1, Z};     // stray tx_done in IDLE
        vecs[44] = '{0, 3'd1, 0, 7'd0, 1, 0, B};     // IN, then OUT instead of ACK
        vecs[45] = '{0, 3'd5, 0, 7'd0, 1, 0, D0};
        vecs[46] = '{0, 3'd5, 0, 7'd0, 1, 1, B};
        vecs[47] = '{0, 3'd2, 0, 7'd0, 0, 0, TXE};
        vecs[48] = '{0, 3'd2, 0, 7'd0, 0, 0, Z};     // OUT not re-processed

        for (int i = 0; i < NV; i++) begin
            rst                  = vecs[i].rst;
            rx_packet            = vecs[i].rxp;
            store_rx_packet_data = vecs[i].st;
            buffer_occupancy     = vecs[i].occ;
            tx_data_ready        = vecs[i].tdr;
            tx_done              = vecs[i].tdone;
            tick();
            check($sformatf("vec%0d", i), act, vecs[i].exp);
        end
        rst = 1'b0;
        store_rx_packet_data = 1'b0;
        tx_done = 1'b0;
        tx_data_ready = 1'b0;

        // 16-byte OUT accepted with ACK
        out_prefix("out16");
        for (int i = 0; i < 16; i++) step($sformatf("out16_b%0d", i), 3'd6, 1'b1, B);
        step("out16_eop", 3'd5, 1'b0, ACKR);
        step("out16_hold", 3'd5, 1'b0, ACKH);
        done_step("out16_txdone", Z);

        // 64 bytes with the last strobe on the DONE cycle: exactly MAX_PKT, ACK
        out_prefix("out64");
        for (int i = 0; i < 63; i++) step($sformatf("out64_b%0d", i), 3'd6, 1'b1, B);
        step("out64_eop_byte", 3'd5, 1'b1, ACKR);
        done_step("out64_txdone", Z);

        // 65 bytes: oversize, error and flush with no handshake
        out_prefix("out65");
        for (int i = 0; i < 65; i++) step($sformatf("out65_b%0d", i), 3'd6, 1'b1, B);
        step("out65_eop", 3'd5, 1'b0, RXEC);
        step("out65_after", 3'd5, 1'b0, Z);

        // Reset while sending DATA0
        step("rst_idle", 3'd0, 1'b0, Z);
        tx_data_ready = 1'b1;
        step("rst_in", 3'd1, 1'b0, B);
        step("rst_indata", 3'd5, 1'b0, D0);
        rst = 1'b1;
        tick();
        check("rst_mid_in_data", act, Z);
        rst = 1'b0;
        step("rst_after", 3'd5, 1'b0, Z);
        tx_data_ready = 1'b1;

        // No host response after DATA0
        step("wait_idle", 3'd0, 1'b0, Z);
        step("wait_in", 3'd1, 1'b0, B);
        step("wait_data0", 3'd5, 1'b0, D0);
        done_step("wait_entry", B);
        tx_data_ready = 1'b0;
`ifdef USB_CTRL_TIMEOUT_EN
        k = 0;
        got = 1'b0;
        while (!got && k < 3000) begin
            tick();
            k++;
            if (tx_error) got = 1'b1;
        end
        check_int("timeout_latency", k, 640);
        check("timeout_exit", act, TXE);
        tick();
        check("timeout_after", act, Z);
`else
        txe_seen = 0;
        got = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (tx_error) txe_seen++;
        end
        check_int("wait_no_tx_error", txe_seen, 0);
        check("wait_busy_2000", act, B);
        step("wait_late_ack", 3'd3, 1'b0, TTDC);
        step("wait_after", 3'd3, 1'b0, Z);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
